// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor r = (a - b) mod Q with valid/ready handshakes.
// Stage 1 forms the raw difference through a Kogge-Stone borrow network; stage 2 folds a borrow back by adding Q.
module mod_sub_pipe #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_err
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] bor;
  logic [WIDTH:0]   diff;

  logic             s1_valid;
  logic [WIDTH:0]   s1_d;
  logic [TAGW-1:0]  s1_tag;
  logic             s1_err;
  logic             s2_valid;

  // Every register moves together; the only stall source is a held result at the output.
  assign adv       = ~s2_valid | out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid & adv;
  assign out_valid = s2_valid;

  // After the last level, g[i] is the borrow out of bit i (borrow-in is zero).
  always_comb begin
    g     = ~a & b;
    p     = ~(a ^ b);
    g_nxt = g;
    p_nxt = p;
    for (int k = 0; k < LEVELS; k++) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = (1 << k); i < WIDTH; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i-(1<<k)]);
        p_nxt[i] = p[i] & p[i-(1<<k)];
      end
      g = g_nxt;
      p = p_nxt;
    end
    bor  = g;
    diff = {bor[WIDTH-1], a ^ b ^ {bor[WIDTH-2:0], 1'b0}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_tag   <= '0;
      s1_err   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_d   <= diff;
        s1_tag <= in_tag;
        s1_err <= (a >= Q_W) | (b >= Q_W);
      end
    end
  end

  // A borrow means the raw difference wrapped below zero, so add Q back modulo 2**WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      r        <= '0;
      out_tag  <= '0;
      out_err  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      r        <= s1_d[WIDTH] ? (s1_d[WIDTH-1:0] + Q_W) : s1_d[WIDTH-1:0];
      out_tag  <= s1_tag;
      out_err  <= s1_err;
    end
  end

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Directed bench for mod_sub_pipe: hand-computed vectors, streaming, backpressure
// and mid-stream reset, checked with immediate assertions and an in-order scoreboard.
module tb_mod_sub_pipe;

  localparam int WIDTH = 12;
  localparam int Q     = 3329;
  localparam int TAGW  = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [TAGW-1:0]  out_tag;
  logic             out_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_recv   = 0;
  logic last_acc;
  logic last_ready;

  int exp_r[$];
  int exp_tag[$];
  int exp_err[$];

  mod_sub_pipe #(.WIDTH(WIDTH), .Q(Q), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: raw 12-bit difference, plus Q modulo 4096 whenever it went negative.
  function automatic int model_r(input int av, input int bv);
    int d;
    d = av - bv;
    if (d < 0) return (d + 4096 + Q) % 4096;
    return d;
  endfunction

  function automatic int model_err(input int av, input int bv);
    return ((av >= Q) || (bv >= Q)) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", name, obs, expv);
    end
  endtask

  // One clock cycle of streaming traffic; the scoreboard follows both handshakes.
  task automatic applyStimulus(input logic v, input int av, input int bv, input int tv, input logic ordy);
    int er, et, ee;
    in_valid  = v;
    a         = av[WIDTH-1:0];
    b         = bv[WIDTH-1:0];
    in_tag    = tv[TAGW-1:0];
    out_ready = ordy;
    #1;
    last_ready = in_ready;
    last_acc   = in_valid & in_ready;
    if (out_valid && out_ready) begin
      if (exp_r.size() == 0) begin
        checkOutput("spurious_out_valid", out_valid, 0);
      end else begin
        er = exp_r.pop_front();
        et = exp_tag.pop_front();
        ee = exp_err.pop_front();
        checkOutput("stream_r", r, er);
        checkOutput("stream_tag", out_tag, et);
        checkOutput("stream_err", out_err, ee);
        n_recv++;
      end
    end
    if (last_acc) begin
      exp_r.push_back(model_r(av, bv));
      exp_tag.push_back(tv % 16);
      exp_err.push_back(model_err(av, bv));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  // Single isolated pair with hand-computed result, checked two cycles after accept.
  task automatic directed(input int av, input int bv, input int tv, input int er, input int ee);
    in_valid  = 1'b1;
    a         = av[WIDTH-1:0];
    b         = bv[WIDTH-1:0];
    in_tag    = tv[TAGW-1:0];
    out_ready = 1'b1;
    #1;
    checkOutput("dir_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("dir_out_valid", out_valid, 1);
    checkOutput("dir_r", r, er);
    checkOutput("dir_tag", out_tag, tv);
    checkOutput("dir_err", out_err, ee);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int j;
    int base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_r", r, 0);
    checkOutput("rst_out_tag", out_tag, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    directed(5, 3, 1, 2, 0);
    directed(3, 5, 2, 3327, 0);
    directed(0, 3328, 3, 1, 0);
    directed(0, 0, 4, 0, 0);
    directed(3328, 0, 5, 3328, 0);
    directed(0, 1, 6, 3328, 0);
    directed(2048, 1, 7, 2047, 0);
    directed(2047, 2048, 8, 3328, 0);
    directed(3329, 0, 9, 3329, 1);
    directed(0, 4095, 10, 3330, 1);
    directed(4095, 4095, 11, 0, 1);

    $display("[TB] back-to-back stream");
    base = n_recv;
    for (int c = 0; c < 32; c++) begin
      applyStimulus(c < 30, (c * 97 + 13) % Q, (c * 211 + 7) % Q, c, 1'b1);
      checkOutput("stream_in_ready", last_ready, 1);
    end
    checkOutput("stream_count", n_recv - base, 30);

    $display("[TB] backpressure hold");
    j = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, (j * 389 + 100) % Q, (j * 701 + 50) % Q, j + 3, 1'b0);
      checkOutput("bp_in_ready", last_ready, (c < 2) ? 1 : 0);
      if (last_acc) j++;
      if (c >= 1) begin
        checkOutput("bp_hold_r", r, model_r(100, 50));
        checkOutput("bp_hold_tag", out_tag, 3);
      end
    end
    checkOutput("bp_accepts", j, 2);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(j < 8, (j * 389 + 100) % Q, (j * 701 + 50) % Q, j + 3, 1'b1);
      if (last_acc) j++;
    end
    checkOutput("bp_drained", exp_r.size(), 0);

    $display("[TB] random backpressure");
    j = 0;
    base = n_recv;
    for (int c = 0; c < 400; c++) begin
      applyStimulus((j < 100) && ($urandom_range(0, 3) != 0),
                    (j * 517 + 29) % 4096, (j * 1231 + 3) % Q, j, $urandom_range(0, 1) == 1);
      if (last_acc) j++;
    end
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 0, 0, 0, 1'b1);
    checkOutput("rand_drained", exp_r.size(), 0);
    checkOutput("rand_recv_eq_acc", n_recv - base, j);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 10, 20, 12, 1'b0);
    applyStimulus(1'b1, 30, 5, 13, 1'b0);
    checkOutput("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_r", r, 0);
    checkOutput("mid_rst_out_tag", out_tag, 0);
    exp_r.delete();
    exp_tag.delete();
    exp_err.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 0, 0, 0, 1'b1);
      checkOutput("post_rst_out_valid", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
